epl_ecc_secded_encoder: RTL
===========================

# epl_ecc_secded_encoder

Parametrised Hamming SEC/SEC-DED encoder with a valid/ready streaming interface and a 2-entry output buffer. It is the next-generation write-path encoder: it generalises the fixed 4-bit/7-bit encoder to any data width from 4 to 64 bits. It adds an optional overall-parity bit for double-error detection, full backpressure, and a saturating accepted-word counter. It sits between the write-data source and the protected storage/link.

## Interface
- DATA_W, 8: data width, legal range 4..64.
- PAR_INV, 1: 1 = Hamming check bits inverted (XOR 1), matching the existing encoder's stored format; 0 = plain even parity.
- EN_OVP, 1: 1 = append overall-parity bit (SEC-DED); 0 = SEC only.
- Derived P: smallest integer with 2^P >= DATA_W+P+1. Derived CW_W = DATA_W+P+EN_OVP.

Ports:
- pCLK_i  in  1  single clock, rising edge.
- nRST_i  in  1  asynchronous, active-low reset.
- pVALID_i  in  1  input word valid.
- pREADY_o  out  1  encoder can accept a word.
- pDATA_i  in  DATA_W  data word.
- pVALID_o  out  1  codeword valid.
- pREADY_i  in  1  downstream accepts codeword.
- pCODEWORD_o  out  CW_W  encoded word.
- pCLR_i  in  1  synchronous clear of pWORDS_o.
- pWORDS_o  out  16  count of codewords delivered, saturating.

## Operation
- Input handshake: in_fire = pVALID_i & pREADY_o. Output handshake: out_fire = pVALID_o & pREADY_i.
- Codeword layout: Hamming positions 1..DATA_W+P map to codeword bit (position-1).
  - Check bit j occupies position 2^j.
  - Data bits fill the remaining positions in ascending order, starting with pDATA_i[0].
- Check bit j = XOR of the data bits whose position has bit j set, XOR PAR_INV.
- Overall parity (EN_OVP=1): bit CW_W-1 = XOR of codeword bits 0..CW_W-2, computed after inversion and never inverted itself.
- Encoding is combinational on pDATA_i. The codeword is written into the buffer on in_fire.
- The buffer is a 2-entry FIFO with states EMPTY, ONE and FULL:
  - EMPTY: in_fire goes to ONE.
  - ONE: in_fire & !out_fire goes to FULL. !in_fire & out_fire goes to EMPTY. Both fire: stay in ONE, the new word becomes the head on the next cycle. Neither fires: hold.
  - FULL: out_fire goes to ONE. in_fire is impossible here.
- pREADY_o = (state != FULL), decoded from the state register only. There is no combinational path from pREADY_i or pVALID_i to pREADY_o.
- pVALID_o = (state != EMPTY).
- pCODEWORD_o = head entry when pVALID_o=1, else all zeros. Stale data is never presented.
- Order is strictly FIFO; no word is dropped or duplicated.
- pWORDS_o increments by 1 on each out_fire and saturates at 0xFFFF.
  - pCLR_i sets it to 0 at the next edge and takes priority over a same-cycle out_fire.
- pDATA_i is ignored when pVALID_i=0 or pREADY_o=0.

## Timing
- Reset values (asynchronous on nRST_i low): state=EMPTY, pVALID_o=0, pCODEWORD_o=0, pWORDS_o=0, pREADY_o=1. Both buffer entries are cleared to 0.
- Inputs are ignored while nRST_i is low. Reset asserted mid-transfer discards all buffered words immediately; no word is emitted after reset release unless it is newly accepted.
- Latency: a word accepted at edge N is on pCODEWORD_o with pVALID_o=1 from just after edge N until its out_fire edge.
- Throughput: 1 word/cycle sustained while pREADY_i=1.
- pVALID_o and pCODEWORD_o are held stable while pVALID_o=1 and pREADY_i=0.
- After a stall with FULL, pREADY_o rises in the cycle after the first out_fire.
- pVALID_o may deassert only in the cycle after an out_fire that empties the buffer.

## Test plan
- DATA_W=4, PAR_INV=1, EN_OVP=0, pREADY_i=1; send 0x0, 0xF, 0x5 on consecutive cycles -> pCODEWORD_o = 7'h0B, 7'h74, 7'h26 on consecutive cycles, each 1 cycle after acceptance; pWORDS_o ends at 3.
- DATA_W=8 defaults, send 0x00 -> pCODEWORD_o = 13'h008B. Sweep all 256 inputs against a reference model with every single-bit flip -> the syndrome identifies the flipped position. With every double-bit flip -> overall parity is even and the syndrome is non-zero.
- DATA_W=4 config, pREADY_i=0, pVALID_i=1 with 0x0, 0xF, 0x5 -> 0x0 and 0xF accepted, pREADY_o=0 after the second accept, 0x5 held. Then pREADY_i=1 -> 0x0B, 0x74, 0x26 emitted in order, no loss or duplication.
- Simultaneous in_fire and out_fire in state ONE for 10 cycles with random data and pREADY_i toggling -> output sequence equals input sequence; pCODEWORD_o=0 whenever pVALID_o=0.
- Assert nRST_i low while FULL -> next cycle pVALID_o=0, pCODEWORD_o=0, pWORDS_o=0, pREADY_o=1; after release, only newly accepted words appear.
- Preload pWORDS_o to 0xFFFE, then 3 out_fires -> pWORDS_o reads 0xFFFF and holds. pCLR_i together with an out_fire -> pWORDS_o=0.

Source files
------------

// File: rtl/epl_ecc_secded_encoder.sv
// Hamming SEC / SEC-DED write-path encoder with valid/ready handshakes,
// a 2-entry output FIFO and a saturating delivered-word counter.
module epl_ecc_secded_encoder #(
    parameter  int DATA_W  = 8,
    parameter  int PAR_INV = 1,
    parameter  int EN_OVP  = 1,
    localparam int P       = (DATA_W <= 4)  ? 3 :
                             (DATA_W <= 11) ? 4 :
                             (DATA_W <= 26) ? 5 :
                             (DATA_W <= 57) ? 6 : 7,
    localparam int N       = DATA_W + P,
    localparam int CW_W    = N + ((EN_OVP != 0) ? 1 : 0)
) (
    input  logic              pCLK_i,
    input  logic              nRST_i,
    input  logic              pVALID_i,
    output logic              pREADY_o,
    input  logic [DATA_W-1:0] pDATA_i,
    output logic              pVALID_o,
    input  logic              pREADY_i,
    output logic [CW_W-1:0]   pCODEWORD_o,
    input  logic              pCLR_i,
    output logic [15:0]       pWORDS_o
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state, state_nxt;
    logic [CW_W-1:0] head, tail, head_nxt, tail_nxt, cw;
    logic [N-1:0]    body;
    logic            in_fire, out_fire;

    assign pREADY_o    = (state != FULL);
    assign pVALID_o    = (state != EMPTY);
    assign in_fire     = pVALID_i & pREADY_o;
    assign out_fire    = pVALID_o & pREADY_i;
    assign pCODEWORD_o = pVALID_o ? head : '0;

    // Data index of a non-power-of-two position = pos - (#powers of two <= pos) - 1.
    always_comb begin : enc
        logic par;
        body = '0;
        par  = 1'b0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0)
                body[pos-1] = pDATA_i[pos - $clog2(pos + 1) - 1];
        end
        for (int j = 0; j < P; j++) begin
            par = (PAR_INV != 0);
            for (int pos = 1; pos <= N; pos++) begin
                if ((((pos >> j) & 1) != 0) && ((pos & (pos - 1)) != 0))
                    par = par ^ body[pos-1];
            end
            body[(1 << j) - 1] = par;
        end
    end

    // Overall parity covers the already-inverted check bits and is never inverted.
    if (EN_OVP != 0) begin : g_ovp
        assign cw = {^body, body};
    end else begin : g_sec
        assign cw = body;
    end

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            EMPTY: if (in_fire) begin
                state_nxt = ONE;
                head_nxt  = cw;
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_nxt = cw;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    tail_nxt  = cw;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (out_fire) begin
                state_nxt = ONE;
                head_nxt  = tail;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge pCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    always_ff @(posedge pCLK_i or negedge nRST_i) begin
        if (!nRST_i)
            pWORDS_o <= '0;
        else if (pCLR_i)
            pWORDS_o <= '0;
        else if (out_fire && (pWORDS_o != 16'hFFFF))
            pWORDS_o <= pWORDS_o + 16'd1;
    end

endmodule
